register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  - 8-entry x 16-bit general-purpose register file for the CPU datapath.
//  - One synchronous write port (W) and two independent combinational read ports (R, S).
//  - Feeds the ALU operand buses; written back from the ALU/memory result bus.
// PARAMETERS
//  DATA_W  16  width of each register and of the W/R/S data buses
//  ADDR_W  3   address width; depth = 2**ADDR_W = 8 registers
// PORTS
//  clk    in   1       single clock; all state changes on rising edge
//  reset  in   1       asynchronous, active-low reset (0 = reset asserted)
//  W_Adr  in   ADDR_W  write address
//  we     in   1       write enable, active high
//  R_Adr  in   ADDR_W  read address, port R
//  S_Adr  in   ADDR_W  read address, port S
//  W      in   DATA_W  write data
//  R      out  DATA_W  contents of register R_Adr
//  S      out  DATA_W  contents of register S_Adr
// BEHAVIOUR
//  - Reset: while reset==0, all 8 registers clear to 16'h0000 immediately, independent of clk.
//    R and S therefore read 16'h0000 for every address.
//  - Reset has priority over write. An active reset overrides a write on the same edge.
//  - Write: on posedge clk with reset==1 and we==1, reg[W_Adr] <= W. All other registers hold.
//  - we==0: no register changes, regardless of W_Adr/W.
//  - Read: R = reg[R_Adr] and S = reg[S_Adr], purely combinational, zero-cycle latency.
//  - Read results follow address changes within the same cycle.
//  - R_Adr == S_Adr is legal; both ports return the same value.
//  - Read-during-write to the same address: there is no write-through bypass.
//    R/S show the old value until the write edge and the new value immediately after it.
//  - Register 0 is an ordinary writable register (not hard-wired to zero).
//  - All address values 0..7 are valid. There is no out-of-range condition.
//  - Reset mid-operation: asserting reset between edges clears contents asynchronously.
//    Writes resume on the first rising edge after reset returns to 1.
// STRUCTURE
//  - Shared package: DATA_W, ADDR_W, NUM_REGS = 8 constants; typedef for a 16-bit data word.
//  - Sub-module reg16: one 16-bit register with async active-low clear and load enable.
//    Instantiate it 8 times.
//  - Top-level logic around the reg16 instances:
//    - 3-to-8 write decoder, gated by we, drives the load enables.
//    - Two 8:1 x 16-bit read multiplexers drive R and S.
// TESTING
//  1. Pulse reset low, then for addr=0..7 set R_Adr=addr, S_Adr=7-addr -> R=S=16'h0000 every address.
//  2. we=1, write W_Adr=a with W=16'h1111*a for a=0..7; read back with R_Adr=a, S_Adr=7-a.
//     -> R=16'h1111*a, S=16'h1111*(7-a).
//  3. we=0, W_Adr=3, W=16'hDEAD for one edge -> reg3 unchanged (R_Adr=3 still 16'h3333).
//  4. R_Adr=W_Adr=5, we=1, W=16'hBEEF:
//     -> R=16'h5555 before the edge, 16'hBEEF after it; S_Adr=5 also reads 16'hBEEF.
//  5. With registers loaded, drop reset mid-cycle (no clk edge) -> R and S go to 16'h0000 at once.
//     A write attempted while reset==0 is ignored.
//  6. Write 16'hFFFF to reg7 and 16'h0001 to reg0 on consecutive edges -> R_Adr=7, S_Adr=0.
//     -> R=16'hFFFF, S=16'h0001; no other register disturbed.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the CPU register file.
//  - DATA_W   : width of one register and of the W/R/S buses
//  - ADDR_W   : register address width
//  - NUM_REGS : number of registers (2**ADDR_W)
//  - word_t   : one data word
//  - decode_onehot : write-address decoder, gated by the write enable
package register_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Returns a one-hot load vector selecting register 'addr'.
  // Returns all zeros when 'en' is low.
  function automatic logic [NUM_REGS-1:0] decode_onehot(input addr_t addr, input logic en);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    if (en) begin
      sel[addr] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/register_file_reg16.sv
// One data word of register-file storage.
// It is cleared asynchronously and loaded synchronously.
// Ports:
//  clk   in  rising-edge clock
//  clr_n in  asynchronous active-low clear; it wins over load
//  load  in  load enable; q takes d on the rising edge
//  d     in  data to load
//  q     out stored word
module register_file_reg16
  import register_file_pkg::*;
(
  input  logic  clk,
  input  logic  clr_n,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  word_t q_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/register_file.sv
// Register file for the CPU datapath: 8 entries x 16 bits.
// It has one synchronous write port and two combinational read ports.
// Ports:
//  clk    in  rising-edge clock
//  reset  in  asynchronous active-low reset; it clears every register
//  W_Adr  in  write address
//  we     in  write enable, active high
//  R_Adr  in  read address for port R
//  S_Adr  in  read address for port S
//  W      in  write data
//  R      out contents of register R_Adr (zero-latency)
//  S      out contents of register S_Adr (zero-latency)
module register_file
  import register_file_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  addr_t W_Adr,
  input  logic  we,
  input  addr_t R_Adr,
  input  addr_t S_Adr,
  input  word_t W,
  output word_t R,
  output word_t S
);

  word_t               reg_q [NUM_REGS];
  logic [NUM_REGS-1:0] load_en;

  // Write decoder.
  // The clear path goes straight to each cell, so reset overrides any load on the same edge.
  assign load_en = decode_onehot(W_Adr, we);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      register_file_reg16 u_reg (
        .clk   (clk),
        .clr_n (reset),
        .load  (load_en[gi]),
        .d     (W),
        .q     (reg_q[gi])
      );
    end
  endgenerate

  // The read muxes use plain selection with no write bypass.
  // A write becomes visible only after its clock edge.
  assign R = reg_q[R_Adr];
  assign S = reg_q[S_Adr];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [2:0]  W_Adr;
  logic        we;
  logic [2:0]  R_Adr;
  logic [2:0]  S_Adr;
  logic [15:0] W;
  logic [15:0] R;
  logic [15:0] S;

  int checks   = 0;
  int failures = 0;

  // Reference contents: one plain array, written on accepted writes, wiped on reset.
  logic [15:0] mdl [8];

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .W_Adr (W_Adr),
    .we    (we),
    .R_Adr (R_Adr),
    .S_Adr (S_Adr),
    .W     (W),
    .R     (R),
    .S     (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wadr;
    logic [15:0] w;
    logic [2:0]  radr;
    logic [2:0]  sadr;
    logic [15:0] exp_r;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; W_Adr = '0; R_Adr = '0; S_Adr = '0; W = '0;
    clear_model();

    // 1. The registers read as zero after reset, for every address.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 8; a++) begin
      R_Adr = 3'(a); S_Adr = 3'(7 - a);
      #1;
      $display("reset read R_Adr=%0d S_Adr=%0d R=%h S=%h", a, 7 - a, R, S);
      check("reset_R", R, 16'h0000);
      check("reset_S", S, 16'h0000);
    end

    // 2 and 3. Table of vectors: write all registers, read them back, then a write with we=0.
    for (int a = 0; a < 8; a++) begin
      vecs[a] = '{1'b1, 3'(a), 16'(16'h1111 * a), 3'(a), 3'(a),
                  16'(16'h1111 * a), 16'(16'h1111 * a)};
      vecs[8 + a] = '{1'b0, 3'(a), 16'hFFFF, 3'(a), 3'(7 - a),
                      16'(16'h1111 * a), 16'(16'h1111 * (7 - a))};
    end
    vecs[16] = '{1'b0, 3'd3, 16'hDEAD, 3'd3, 3'd4, 16'h3333, 16'h4444};

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      we = vecs[i].we; W_Adr = vecs[i].wadr; W = vecs[i].w;
      R_Adr = vecs[i].radr; S_Adr = vecs[i].sadr;
      @(posedge clk);
      if (we) mdl[W_Adr] = W;
      #1;
      $display("vec %0d we=%0b W_Adr=%0d W=%h R_Adr=%0d S_Adr=%0d R=%h S=%h",
               i, vecs[i].we, vecs[i].wadr, vecs[i].w, vecs[i].radr, vecs[i].sadr, R, S);
      check("vec_R", R, vecs[i].exp_r);
      check("vec_S", S, vecs[i].exp_s);
    end

    // 4. Read during a write to the same address: no bypass, new value after the edge.
    @(negedge clk);
    R_Adr = 3'd5; W_Adr = 3'd5; we = 1'b1; W = 16'hBEEF; S_Adr = 3'd2;
    #1;
    $display("rdw before edge R=%h", R);
    check("rdw_before", R, 16'h5555);
    @(posedge clk);
    mdl[5] = 16'hBEEF;
    #1;
    $display("rdw after edge R=%h", R);
    check("rdw_after", R, 16'hBEEF);
    S_Adr = 3'd5;
    #1;
    $display("rdw same address S=%h", S);
    check("rdw_S_same", S, 16'hBEEF);
    we = 1'b0;

    // 5. Asynchronous reset between edges. A write during reset is ignored.
    @(negedge clk);
    R_Adr = 3'd1; S_Adr = 3'd6;
    #2;
    reset = 1'b0;
    clear_model();
    #1;
    $display("async reset R=%h S=%h", R, S);
    check("async_rst_R", R, 16'h0000);
    check("async_rst_S", S, 16'h0000);
    we = 1'b1; W_Adr = 3'd2; W = 16'h1234; R_Adr = 3'd2;
    @(posedge clk);
    #1;
    $display("write under reset R=%h", R);
    check("wr_in_reset", R, 16'h0000);
    @(negedge clk);
    we = 1'b0; reset = 1'b1;
    #1;
    check("after_release", R, 16'h0000);

    // 6. Boundary registers written on consecutive edges.
    @(negedge clk);
    we = 1'b1; W_Adr = 3'd7; W = 16'hFFFF;
    @(negedge clk);
    mdl[7] = 16'hFFFF;
    W_Adr = 3'd0; W = 16'h0001;
    @(negedge clk);
    mdl[0] = 16'h0001;
    we = 1'b0; R_Adr = 3'd7; S_Adr = 3'd0;
    #1;
    $display("boundary R=%h S=%h", R, S);
    check("bound_R7", R, 16'hFFFF);
    check("bound_S0", S, 16'h0001);
    for (int a = 1; a < 7; a++) begin
      R_Adr = 3'(a);
      #1;
      check("bound_other", R, 16'h0000);
    end

    // Random traffic checked against the array model.
    // An async reset is inserted occasionally between clock edges.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      reset = 1'b1;
      we    = 1'($urandom_range(0, 1));
      W_Adr = 3'($urandom_range(0, 7));
      R_Adr = 3'($urandom_range(0, 7));
      S_Adr = 3'($urandom_range(0, 7));
      W     = 16'($urandom);
      #1;
      check("rand_pre_R", R, mdl[R_Adr]);
      check("rand_pre_S", S, mdl[S_Adr]);
      @(posedge clk);
      if (we) mdl[W_Adr] = W;
      #1;
      $display("rand %0d we=%0b W_Adr=%0d W=%h R_Adr=%0d R=%h S_Adr=%0d S=%h",
               n, we, W_Adr, W, R_Adr, R, S_Adr, S);
      check("rand_post_R", R, mdl[R_Adr]);
      check("rand_post_S", S, mdl[S_Adr]);
      if ($urandom_range(0, 31) == 0) begin
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        $display("rand %0d async reset R=%h S=%h", n, R, S);
        check("rand_rst_R", R, mdl[R_Adr]);
        check("rand_rst_S", S, mdl[S_Adr]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
